// File: rtl/usb_out_pkg.sv
// Shared types and constants for the USB OUT endpoint arbiter.
package usb_out_pkg;

  localparam int EP_ADDR_W = 4;
  localparam int MAX_EP    = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DISCARD = 2'd2,
    ST_STALL   = 2'd3
  } out_state_e;

  // Endpoint 0 is the control pipe and never routed here; numbers above
  // n_ep have no receiver behind them.
  function automatic logic ep_in_range(input logic [EP_ADDR_W-1:0] ep,
                                       input int n_ep);
    return (ep != '0) && (int'(ep) <= n_ep);
  endfunction

endpackage

// File: rtl/out_ep_arbiter.sv
// OUT endpoint arbiter: steers the SIE OUT stream to one of N_EP endpoint
// FIFOs, tracks the DATA0/DATA1 toggle of every endpoint, drops duplicate
// packets (ACKed, never delivered) and answers halted endpoints with STALL.
// Optional feature: define OUT_EP_STALL_EN to honour ep_halt_i; without it
// the halt inputs are ignored and sie_stall_o is held low.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no transaction open, waiting for sie_start_i
// ST_ACTIVE  | packet streamed through to endpoint sel_q
// ST_DISCARD | bad endpoint or duplicate: data swallowed, no NAK
// ST_STALL   | halted endpoint: STALL requested, data swallowed
module out_ep_arbiter
  import usb_out_pkg::*;
#(
  parameter int N_EP = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 sie_start_i,
  input  logic [EP_ADDR_W-1:0] sie_ep_i,
  input  logic                 sie_toggle_i,
  input  logic [7:0]           sie_data_i,
  input  logic                 sie_valid_i,
  input  logic                 sie_err_i,
  input  logic                 sie_ready_i,
  output logic                 sie_nak_o,
  output logic                 sie_stall_o,
  output logic [7:0]           ep_data_o,
  output logic [N_EP-1:0]      ep_valid_o,
  output logic [N_EP-1:0]      ep_err_o,
  output logic [N_EP-1:0]      ep_ready_o,
  input  logic [N_EP-1:0]      ep_nak_i,
  input  logic [N_EP-1:0]      ep_halt_i,
  input  logic [N_EP-1:0]      ep_clr_toggle_i
);

  out_state_e           state_q, state_d;
  out_state_e           tok_state;
  logic [EP_ADDR_W-1:0] sel_q, sel_d;
  logic [EP_ADDR_W-1:0] tok_idx;
  logic                 tok_ok;
  logic                 flip_req;
  logic [N_EP-1:0]      sel_oh;
  logic [N_EP-1:0]      toggle_q;

  // Per-endpoint vectors widened to the full address space so a 4-bit index
  // can never fall outside them; unused upper bits read as zero.
  logic [MAX_EP:0]      toggle_ext;
  logic [MAX_EP:0]      nak_ext;
  logic [MAX_EP:0]      halt_ext;

  assign ep_data_o  = sie_data_i;
  assign toggle_ext = (MAX_EP+1)'(toggle_q);
  assign nak_ext    = (MAX_EP+1)'(ep_nak_i);

`ifdef OUT_EP_STALL_EN
  assign halt_ext = (MAX_EP+1)'(ep_halt_i);
`else
  logic unused_halt;
  assign halt_ext    = '0;
  assign unused_halt = ^ep_halt_i;
`endif

  assign tok_ok  = ep_in_range(sie_ep_i, N_EP);
  assign tok_idx = sie_ep_i - EP_ADDR_W'(1);

  // Classify an incoming token: where does its packet go.
  always_comb begin
    tok_state = ST_DISCARD;
    if (!tok_ok) begin
      tok_state = ST_DISCARD;
    end else if (halt_ext[tok_idx]) begin
      tok_state = ST_STALL;
    end else if (sie_toggle_i != toggle_ext[tok_idx]) begin
      tok_state = ST_DISCARD;
    end else begin
      tok_state = ST_ACTIVE;
    end
  end

  // State and selected-endpoint registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next state, stream steering and SIE handshake outputs.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ep_valid_o  = '0;
    ep_err_o    = '0;
    ep_ready_o  = '0;
    sie_nak_o   = 1'b0;
    sie_stall_o = 1'b0;
    flip_req    = 1'b0;

    // A new token is honoured in every state; a packet still open in
    // ST_ACTIVE is aborted below in the same cycle.
    if (sie_start_i) begin
      state_d = tok_state;
      if (tok_ok) begin
        sel_d = tok_idx;
      end
    end

    case (state_q)
      ST_IDLE: begin
      end
      ST_ACTIVE: begin
        sie_nak_o = nak_ext[sel_q];
        if (sie_start_i) begin
          // End of the old packet was lost: tell its FIFO to roll back.
          ep_err_o   = sel_oh;
          ep_ready_o = sel_oh;
        end else begin
          ep_valid_o = {N_EP{sie_valid_i}} & sel_oh;
          ep_err_o   = {N_EP{sie_err_i}}   & sel_oh;
          ep_ready_o = {N_EP{sie_ready_i}} & sel_oh;
          if (sie_ready_i && (sie_err_i || !sie_valid_i)) begin
            state_d = ST_IDLE;
            // Only a clean, accepted packet advances the sequence bit.
            flip_req = !sie_err_i && !nak_ext[sel_q];
          end
        end
      end
      ST_DISCARD, ST_STALL: begin
`ifdef OUT_EP_STALL_EN
        sie_stall_o = (state_q == ST_STALL);
`endif
        if (!sie_start_i && sie_ready_i && (sie_err_i || !sie_valid_i)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  for (genvar k = 0; k < N_EP; k++) begin : g_ep
    logic tog_q;
    logic halt_fall;

    assign sel_oh[k]   = (sel_q == EP_ADDR_W'(k));
    assign toggle_q[k] = tog_q;

`ifdef OUT_EP_STALL_EN
    logic halt_q;

    // Remember last halt level so releasing the halt restarts at DATA0.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        halt_q <= 1'b0;
      end else begin
        halt_q <= ep_halt_i[k];
      end
    end

    assign halt_fall = halt_q & ~ep_halt_i[k];
`else
    assign halt_fall = 1'b0;
`endif

    // Data toggle: explicit clears beat the end-of-packet inversion.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        tog_q <= 1'b0;
      end else if (ep_clr_toggle_i[k] || halt_fall) begin
        tog_q <= 1'b0;
      end else if (flip_req && sel_oh[k]) begin
        tog_q <= ~tog_q;
      end
    end
  end

endmodule

// File: tb/tb_out_ep_arbiter.sv
// Self-checking bench for out_ep_arbiter: directed scenarios followed by
// randomized packets, every cycle compared against a packet-level model.
module tb_out_ep_arbiter;

  localparam int N = 4;

`ifdef OUT_EP_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         sie_start_i;
  logic [3:0]   sie_ep_i;
  logic         sie_toggle_i;
  logic [7:0]   sie_data_i;
  logic         sie_valid_i;
  logic         sie_err_i;
  logic         sie_ready_i;
  logic         sie_nak_o;
  logic         sie_stall_o;
  logic [7:0]   ep_data_o;
  logic [N-1:0] ep_valid_o;
  logic [N-1:0] ep_err_o;
  logic [N-1:0] ep_ready_o;
  logic [N-1:0] ep_nak_i;
  logic [N-1:0] ep_halt_i;
  logic [N-1:0] ep_clr_toggle_i;

  always #5 clk_i = ~clk_i;

  out_ep_arbiter #(.N_EP(N)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .sie_start_i     (sie_start_i),
    .sie_ep_i        (sie_ep_i),
    .sie_toggle_i    (sie_toggle_i),
    .sie_data_i      (sie_data_i),
    .sie_valid_i     (sie_valid_i),
    .sie_err_i       (sie_err_i),
    .sie_ready_i     (sie_ready_i),
    .sie_nak_o       (sie_nak_o),
    .sie_stall_o     (sie_stall_o),
    .ep_data_o       (ep_data_o),
    .ep_valid_o      (ep_valid_o),
    .ep_err_o        (ep_err_o),
    .ep_ready_o      (ep_ready_o),
    .ep_nak_i        (ep_nak_i),
    .ep_halt_i       (ep_halt_i),
    .ep_clr_toggle_i (ep_clr_toggle_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: where the current packet is going and each
  // endpoint's expected next DATA PID.
  localparam int P_NONE = 0, P_DELIVER = 1, P_DROP = 2, P_STALL = 3;
  int pkt_kind = P_NONE;
  int pkt_ep   = 0;
  bit exp_pid [N];
  bit halt_prev [N];

  int obs_bytes [N];
  int obs_abort [N];

  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin
      obs_bytes[k] = 0;
      obs_abort[k] = 0;
    end
  endtask

  task automatic model_reset();
    pkt_kind = P_NONE;
    pkt_ep   = 0;
    for (int k = 0; k < N; k++) begin
      exp_pid[k]   = 1'b0;
      halt_prev[k] = 1'b0;
    end
  endtask

  // One clock: drive, compare against the model, advance the model.
  task automatic step(input bit st, input logic [3:0] ep, input bit tg,
                      input bit v, input bit e, input bit r,
                      input logic [7:0] d, input logic [N-1:0] clr);
    logic [N-1:0] x_valid, x_err, x_ready;
    bit x_nak, x_stall;
    int flip;
    sie_start_i     = st;
    sie_ep_i        = ep;
    sie_toggle_i    = tg;
    sie_valid_i     = v;
    sie_err_i       = e;
    sie_ready_i     = r;
    sie_data_i      = d;
    ep_clr_toggle_i = clr;
    #2;
    x_valid = '0;
    x_err   = '0;
    x_ready = '0;
    x_nak   = 1'b0;
    x_stall = STALL_EN && (pkt_kind == P_STALL);
    if (pkt_kind == P_DELIVER) begin
      x_nak = ep_nak_i[pkt_ep];
      if (st) begin
        x_err[pkt_ep]   = 1'b1;
        x_ready[pkt_ep] = 1'b1;
      end else begin
        x_valid[pkt_ep] = v;
        x_err[pkt_ep]   = e;
        x_ready[pkt_ep] = r;
      end
    end
    check_val("ep_valid", 32'(ep_valid_o), 32'(x_valid));
    check_val("ep_err",   32'(ep_err_o),   32'(x_err));
    check_val("ep_ready", 32'(ep_ready_o), 32'(x_ready));
    check_val("sie_nak",  32'(sie_nak_o),  32'(x_nak));
    check_val("sie_stall", 32'(sie_stall_o), 32'(x_stall));
    check_val("ep_data",  32'(ep_data_o),  32'(d));
    for (int k = 0; k < N; k++) begin
      if (ep_ready_o[k] && ep_valid_o[k] && !ep_err_o[k]) obs_bytes[k]++;
      if (ep_ready_o[k] && ep_err_o[k]) obs_abort[k]++;
    end

    flip = -1;
    if (st) begin
      if (ep == 0 || int'(ep) > N) begin
        pkt_kind = P_DROP;
      end else if (STALL_EN && ep_halt_i[ep-1]) begin
        pkt_kind = P_STALL;
      end else if (tg != exp_pid[ep-1]) begin
        pkt_kind = P_DROP;
      end else begin
        pkt_kind = P_DELIVER;
        pkt_ep   = int'(ep) - 1;
      end
    end else if (pkt_kind == P_DELIVER && r && (e || !v)) begin
      if (!e && !ep_nak_i[pkt_ep]) flip = pkt_ep;
      pkt_kind = P_NONE;
    end else if (pkt_kind != P_NONE && r && (e || !v)) begin
      pkt_kind = P_NONE;
    end
    for (int k = 0; k < N; k++) begin
      if (clr[k]) exp_pid[k] = 1'b0;
      else if (STALL_EN && halt_prev[k] && !ep_halt_i[k]) exp_pid[k] = 1'b0;
      else if (flip == k) exp_pid[k] = ~exp_pid[k];
      halt_prev[k] = ep_halt_i[k];
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0, 0, 8'($urandom), '0);
  endtask

  localparam int END_OK = 0, END_ERR = 1, END_NONE = 2;

  task automatic send_pkt(input logic [3:0] ep, input bit tg, input int nb,
                          input int ending, input logic [N-1:0] clr_end);
    step(1, ep, tg, 0, 0, 0, 8'($urandom), '0);
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 3) != 0) break;
        step(0, 4'd0, 0, 1'($urandom), 0, 0, 8'($urandom), '0);
      end
      step(0, 4'd0, 0, 1, 0, 1, 8'($urandom), '0);
    end
    if (ending == END_OK)
      step(0, 4'd0, 0, 0, 0, 1, 8'($urandom), clr_end);
    else if (ending == END_ERR)
      step(0, 4'd0, 0, 1'($urandom), 1, 1, 8'($urandom), clr_end);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    sie_data_i = 8'hA5;
    #2;
    check_val("rst_valid", 32'(ep_valid_o), 32'd0);
    check_val("rst_err",   32'(ep_err_o),   32'd0);
    check_val("rst_ready", 32'(ep_ready_o), 32'd0);
    check_val("rst_nak",   32'(sie_nak_o),  32'd0);
    check_val("rst_stall", 32'(sie_stall_o), 32'd0);
    check_val("rst_data",  32'(ep_data_o),  32'hA5);
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    sie_start_i = 0; sie_ep_i = 0; sie_toggle_i = 0; sie_data_i = 0;
    sie_valid_i = 0; sie_err_i = 0; sie_ready_i = 0;
    ep_nak_i = '0; ep_halt_i = '0; ep_clr_toggle_i = '0;
    rstn_i = 1'b0;
    #1;
    do_reset();
    idle(2);

    // ep 2, DATA0, eight bytes delivered to index 1 only
    clear_counts();
    send_pkt(4'd2, 0, 8, END_OK, '0);
    check_val("ep2_bytes", 32'(obs_bytes[1]), 32'd8);
    check_val("ep2_others", 32'(obs_bytes[0] + obs_bytes[2] + obs_bytes[3]), 32'd0);

    // repeat DATA0 on ep 2 is a duplicate
    clear_counts();
    idle(1);
    send_pkt(4'd2, 0, 4, END_OK, '0);
    check_val("dup_bytes", 32'(obs_bytes[1]), 32'd0);

    // FIFO NAK on ep 1 keeps the toggle; resending DATA0 is then accepted
    ep_nak_i = 4'b0001;
    send_pkt(4'd1, 0, 3, END_OK, '0);
    ep_nak_i = '0;
    clear_counts();
    send_pkt(4'd1, 0, 2, END_OK, '0);
    check_val("nak_retry_bytes", 32'(obs_bytes[0]), 32'd2);

    // lost end on ep 3: one abort pulse, then ep 1 active
    clear_counts();
    send_pkt(4'd3, 0, 3, END_NONE, '0);
    send_pkt(4'd1, 1, 2, END_OK, '0);
    check_val("abort_pulses", 32'(obs_abort[2]), 32'd1);
    check_val("after_abort_bytes", 32'(obs_bytes[0]), 32'd2);

    // halted ep 4
    clear_counts();
    ep_halt_i = 4'b1000;
    send_pkt(4'd4, 0, 3, END_OK, '0);
    check_val("halt_bytes", 32'(obs_bytes[3]), STALL_EN ? 32'd0 : 32'd3);
    idle(1);
    ep_halt_i = '0;
    idle(2);
    clear_counts();
    send_pkt(4'd4, 0, 2, END_OK, '0);
    check_val("post_halt_bytes", 32'(obs_bytes[3]), STALL_EN ? 32'd2 : 32'd0);

    // out-of-range endpoints
    clear_counts();
    send_pkt(4'd0, 0, 2, END_OK, '0);
    send_pkt(4'(N + 1), 0, 2, END_ERR, '0);
    check_val("bad_ep_bytes", 32'(obs_bytes[0] + obs_bytes[1] + obs_bytes[2] + obs_bytes[3]), 32'd0);

    // clear coincident with end: ep 3 at DATA1 -> stays DATA0
    send_pkt(4'd3, 1, 2, END_OK, 4'b0100);
    clear_counts();
    send_pkt(4'd3, 0, 1, END_OK, '0);
    check_val("clr_end_bytes", 32'(obs_bytes[2]), 32'd1);

    // reset in the middle of a packet
    send_pkt(4'd2, 1, 2, END_NONE, '0);
    sie_valid_i = 1; sie_ready_i = 1;
    do_reset();
    clear_counts();
    send_pkt(4'd2, 0, 2, END_OK, '0);
    check_val("post_rst_bytes", 32'(obs_bytes[1]), 32'd2);

    // randomized traffic
    for (int p = 0; p < 300; p++) begin
      logic [3:0] ep;
      bit tg;
      int ending;
      logic [N-1:0] clr;
      ep = 4'($urandom_range(0, N + 1));
      if (ep != 0 && int'(ep) <= N && $urandom_range(0, 9) < 7) tg = exp_pid[ep-1];
      else tg = 1'($urandom);
      ending = ($urandom_range(0, 19) == 0) ? END_NONE :
               ($urandom_range(0, 9) == 0) ? END_ERR : END_OK;
      clr = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      ep_nak_i = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 14) == 0) ep_halt_i = N'($urandom) & N'($urandom);
      send_pkt(ep, tg, $urandom_range(0, 5), ending, clr);
      if ($urandom_range(0, 2) == 0)
        step(0, 4'd0, 0, 0, 0, 0, 8'($urandom),
             ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/out_ep_arbiter.md
OUT_EP_ARBITER -- requirements
Module: out_ep_arbiter

Interface
REQ-001 Parameter N_EP, default 4, number of OUT endpoints served (legal 1..15); endpoint number k (1..N_EP) maps to port index k-1.
REQ-002 clk_i  in  1  12MHz*BIT_SAMPLES clock; reset rstn_i, asynchronous, active-low; clock clk_i.
REQ-003 rstn_i  in  1  asynchronous active-low reset.
REQ-004 sie_start_i  in  1  one-cycle pulse: OUT token plus DATA PID received for a new transaction.
REQ-005 sie_ep_i  in  4  endpoint number of the token, valid with sie_start_i.
REQ-006 sie_toggle_i  in  1  DATA PID toggle (0=DATA0, 1=DATA1), valid with sie_start_i.
REQ-007 sie_data_i  in  8; sie_valid_i  in  1; sie_err_i  in  1; sie_ready_i  in  1 -- SIE OUT stream, same valid/err/ready semantics as the OUT FIFO port.
REQ-008 sie_nak_o  out  1  NAK request to SIE; sie_stall_o  out  1  STALL request to SIE.
REQ-009 ep_data_o  out  8  sie_data_i broadcast to all endpoints.
REQ-010 ep_valid_o, ep_err_o, ep_ready_o  out  N_EP  per-endpoint OUT stream, active only at selected index.
REQ-011 ep_nak_i  in  N_EP  per-endpoint FIFO NAK; ep_halt_i  in  N_EP  endpoint halt; ep_clr_toggle_i  in  N_EP  one-cycle toggle reset (SET_CONFIGURATION/CLEAR_FEATURE).

Function
REQ-012 States IDLE, ACTIVE, DISCARD, STALL; register sel_q holds selected index.
REQ-013 IDLE + sie_start_i: invalid ep (0 or >N_EP) -> DISCARD; halted ep (REQ-025) -> STALL; sie_toggle_i != toggle_q[ep] -> DISCARD (duplicate); else -> ACTIVE; sel_q loaded the same edge.
REQ-014 ACTIVE: ep_valid_o/ep_err_o/ep_ready_o[sel_q] = sie_valid_i/sie_err_i/sie_ready_i combinationally, zero latency; all other bits 0.
REQ-015 ACTIVE: sie_nak_o = ep_nak_i[sel_q] combinationally.
REQ-016 ACTIVE + sie_ready_i + !sie_valid_i + !sie_err_i (end): if ep_nak_i[sel_q]=0 toggle_q[sel_q] inverts; -> IDLE.
REQ-017 ACTIVE + sie_ready_i + sie_err_i: error forwarded, toggle unchanged, -> IDLE.
REQ-018 DISCARD: all ep_* outputs 0, data dropped, sie_nak_o=0 (duplicate is ACKed); end or error -> IDLE; toggle unchanged.
REQ-019 sie_start_i in ACTIVE (lost end): one-cycle ep_err_o[sel_q] and ep_ready_o[sel_q] pulse aborting old packet, then REQ-013 evaluated on the new token same edge.
REQ-020 sie_start_i in DISCARD/STALL: REQ-013 evaluated directly.
REQ-021 ep_clr_toggle_i[k] clears toggle_q[k] to 0; takes priority over REQ-016 inversion on the same cycle.

Reset
REQ-022 Reset: state IDLE, sel_q 0, toggle_q all 0.
REQ-023 During and after reset: sie_nak_o 0, sie_stall_o 0, all ep_valid_o/ep_err_o/ep_ready_o 0; ep_data_o = sie_data_i.
REQ-024 Reset mid-transaction abandons it; no ep_err_o pulse generated.

Configuration
REQ-025 Macro OUT_EP_STALL_EN defined: ep_halt_i[k] high at start -> STALL; sie_stall_o=1 in STALL, data dropped, -> IDLE on end/error; falling edge of ep_halt_i[k] clears toggle_q[k].
REQ-026 Macro undefined: ep_halt_i ignored (port kept), STALL unreachable, sie_stall_o tied 0.

Structure
REQ-027 Package usb_out_pkg: state encoding typedef, EP_ADDR_W=4, MAX_EP=15.
REQ-028 No sub-module; per-endpoint toggle/halt-edge logic in a generate loop within this module.

Verification
REQ-029 Start ep=2 toggle=0, 8 bytes, end -> 8 ep_ready_o[1] pulses carrying bytes, toggle_q[1]=1, others idle.
REQ-030 Repeat ep=2 with toggle=0 -> DISCARD, no ep_* activity, sie_nak_o=0, toggle_q[1] stays 1.
REQ-031 ep_nak_i[0]=1 during ep=1 packet -> sie_nak_o=1, toggle_q[0] unchanged after end.
REQ-032 Start ep=3, 3 bytes, then sie_start_i ep=1 with no end -> one ep_err_o[2]+ep_ready_o[2] pulse, then ACTIVE on index 0.
REQ-033 OUT_EP_STALL_EN, ep_halt_i[3]=1, start ep=4 -> sie_stall_o=1, no data; release halt -> toggle_q[3]=0; without macro same stimulus -> normal ACTIVE.
REQ-034 Start ep=0 or ep=N_EP+1 -> DISCARD; ep_clr_toggle_i coincident with end -> toggle_q=0.
